// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Multithreaded instruction-fetch stage that sits directly upstream of the
// hazard unit. It keeps one PC and one run/wait state per hardware thread.
// Each cycle it picks a ready thread round-robin and issues that thread's PC
// to the I-cache/I-TLB (F1). One cycle later (F2) it forwards the returned
// instruction, together with the thread id and the miss flags, to the
// hazard unit.
//
// A thread that misses parks in a wait state until the matching refill
// completes. Branch redirects and hazard-unit replays rewrite per-thread PCs.
//
// Optional feature macro: FETCH_ITLB_EN
//   defined   : WAIT_TLB state exists; tlb_rsp_miss and tlb_fill_* are honoured
//   undefined : tlb_rsp_miss and tlb_fill_* are ignored, f_itlb_miss is 0,
//               and every miss parks the thread in WAIT_IC
//
// Parameters
//   NTHREADS  number of hardware threads (power of 2, 2..8)
//   BOOT_PC   reset PC of every thread
//
// Ports
//   clk, rst                              clock, synchronous active-high reset
//   ic_req_valid/_pc/_thread        out   F1 lookup request
//   ic_rsp_instr, ic_rsp_miss       in    cache response for last cycle's request
//   tlb_rsp_miss                    in    TLB miss for last cycle's request
//   ic_fill_done/_thread            in    I-cache refill complete for a thread
//   tlb_fill_done/_thread           in    I-TLB refill complete for a thread
//   redir_valid/_thread/_pc         in    branch redirect
//   replay_valid/_thread/_pc        in    hazard-unit replay
//   f_valid/_thread/_pc/_instr      out   F2 fetch slot to the hazard unit
//   f_icache_miss, f_itlb_miss      out   miss flags, qualified by f_valid
//
// Handshake: there is no back-pressure on either side. ic_req_valid marks a
// lookup whose response arrives on ic_rsp_* exactly one cycle later.
// f_valid marks a slot that the hazard unit must consume in the same cycle.
// A slot whose thread was updated in the issue cycle is never produced, so
// a squashed slot shows up as f_valid=0.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int          NTHREADS = 4,
    parameter logic [31:0] BOOT_PC  = 32'h0000_1000,
    localparam int         TW       = $clog2(NTHREADS)
) (
    input  logic          clk,
    input  logic          rst,

    output logic          ic_req_valid,
    output logic [31:0]   ic_req_pc,
    output logic [TW-1:0] ic_req_thread,

    input  logic [31:0]   ic_rsp_instr,
    input  logic          ic_rsp_miss,
    input  logic          tlb_rsp_miss,

    input  logic          ic_fill_done,
    input  logic [TW-1:0] ic_fill_thread,
    input  logic          tlb_fill_done,
    input  logic [TW-1:0] tlb_fill_thread,

    input  logic          redir_valid,
    input  logic [TW-1:0] redir_thread,
    input  logic [31:0]   redir_pc,

    input  logic          replay_valid,
    input  logic [TW-1:0] replay_thread,
    input  logic [31:0]   replay_pc,

    output logic          f_valid,
    output logic [TW-1:0] f_thread,
    output logic [31:0]   f_pc,
    output logic [31:0]   f_instr,
    output logic          f_icache_miss,
    output logic          f_itlb_miss
);

    // -----------------------------------------------------------------------
    // Per-thread state encoding
    // -----------------------------------------------------------------------
`ifdef FETCH_ITLB_EN
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_IC  = 2'd1,
        ST_WAIT_TLB = 2'd2
    } thread_st_e;
`else
    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_WAIT_IC = 1'b1
    } thread_st_e;
`endif

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [31:0]   pc_q       [NTHREADS];
    logic [31:0]   pc_d       [NTHREADS];
    thread_st_e    st_q       [NTHREADS];
    thread_st_e    st_d       [NTHREADS];
    logic [TW-1:0] last_sel_q;
    logic [TW-1:0] last_sel_d;

    // F2 slot registers
    logic          s_valid_q;
    logic          s_valid_d;
    logic [TW-1:0] s_thread_q;
    logic [TW-1:0] s_thread_d;
    logic [31:0]   s_pc_q;
    logic [31:0]   s_pc_d;

    // -----------------------------------------------------------------------
    // TLB inputs, folded to constants when the I-TLB path is compiled out
    // -----------------------------------------------------------------------
    logic tlb_miss_eff;

`ifdef FETCH_ITLB_EN
    assign tlb_miss_eff = tlb_rsp_miss;
`else
    logic unused_tlb;
    assign tlb_miss_eff = 1'b0;
    assign unused_tlb   = ^{tlb_rsp_miss, tlb_fill_done, tlb_fill_thread};
`endif

    // -----------------------------------------------------------------------
    // F2 outputs. Reset masks the slot combinationally so that nothing
    // leaves the stage while rst is high, even in the first reset cycle.
    // -----------------------------------------------------------------------
    logic f_valid_int;
    logic miss_f2;

    assign f_valid_int   = s_valid_q & ~rst;
    assign f_valid       = f_valid_int;
    assign f_thread      = s_thread_q;
    assign f_pc          = s_pc_q;
    assign f_instr       = ic_rsp_instr;
    assign f_icache_miss = f_valid_int & ic_rsp_miss;
    assign f_itlb_miss   = f_valid_int & tlb_miss_eff;
    assign miss_f2       = f_valid_int & (ic_rsp_miss | tlb_miss_eff);

    // -----------------------------------------------------------------------
    // Per-thread updates (redirect > replay > F2 miss > fill), then the
    // round-robin select over threads left untouched this cycle.
    // -----------------------------------------------------------------------
    logic [NTHREADS-1:0] upd;
    logic                sel_found;
    logic [TW-1:0]       sel_idx;
    logic [TW-1:0]       cand;

    always_comb begin
        for (int t = 0; t < NTHREADS; t++) begin
            pc_d[t] = pc_q[t];
            st_d[t] = st_q[t];
        end
        upd = '0;

        for (int t = 0; t < NTHREADS; t++) begin
            if (redir_valid && redir_thread == TW'(t)) begin
                // A redirect also cancels any outstanding wait.
                pc_d[t] = redir_pc;
                st_d[t] = ST_RUN;
                upd[t]  = 1'b1;
            end else if (replay_valid && replay_thread == TW'(t)) begin
                pc_d[t] = replay_pc;
                upd[t]  = 1'b1;
            end else if (miss_f2 && s_thread_q == TW'(t)) begin
                // Rewind to the missing PC; the TLB miss wins over the
                // cache miss because the cache data is meaningless without
                // a translation.
                pc_d[t] = s_pc_q;
`ifdef FETCH_ITLB_EN
                st_d[t] = tlb_miss_eff ? ST_WAIT_TLB : ST_WAIT_IC;
`else
                st_d[t] = ST_WAIT_IC;
`endif
                upd[t]  = 1'b1;
            end else if (ic_fill_done && ic_fill_thread == TW'(t) &&
                         st_q[t] == ST_WAIT_IC) begin
                st_d[t] = ST_RUN;
                upd[t]  = 1'b1;
`ifdef FETCH_ITLB_EN
            end else if (tlb_fill_done && tlb_fill_thread == TW'(t) &&
                         st_q[t] == ST_WAIT_TLB) begin
                st_d[t] = ST_RUN;
                upd[t]  = 1'b1;
`endif
            end
        end

        // The search starts just after the last granted thread. The TW-bit
        // add wraps naturally because NTHREADS is a power of two.
        sel_found = 1'b0;
        sel_idx   = last_sel_q;
        cand      = last_sel_q;
        for (int i = 1; i <= NTHREADS; i++) begin
            cand = last_sel_q + TW'(i);
            if (!sel_found && st_q[cand] == ST_RUN && !upd[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end

        // A selected thread is never updated in the same cycle, so the +4
        // advance cannot collide with the assignments above.
        if (sel_found) begin
            pc_d[sel_idx] = pc_q[sel_idx] + 32'd4;
        end

        last_sel_d = sel_found ? sel_idx : last_sel_q;
        s_valid_d  = sel_found;
        s_thread_d = sel_idx;
        s_pc_d     = pc_q[sel_idx];
    end

    assign ic_req_valid  = sel_found & ~rst;
    assign ic_req_pc     = pc_q[sel_idx];
    assign ic_req_thread = sel_idx;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NTHREADS; t++) begin
                pc_q[t] <= BOOT_PC;
                st_q[t] <= ST_RUN;
            end
            last_sel_q <= TW'(NTHREADS - 1);
            s_valid_q  <= 1'b0;
            s_thread_q <= '0;
            s_pc_q     <= '0;
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                pc_q[t] <= pc_d[t];
                st_q[t] <= st_d[t];
            end
            last_sel_q <= last_sel_d;
            s_valid_q  <= s_valid_d;
            s_thread_q <= s_thread_d;
            s_pc_q     <= s_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int NT = 4;
  localparam int TW = 2;
  localparam logic [31:0] BOOT = 32'h0000_1000;
  localparam int NCYC = 3000;
`ifdef FETCH_ITLB_EN
  localparam bit ITLB_EN = 1'b1;
`else
  localparam bit ITLB_EN = 1'b0;
`endif

  // model thread states
  localparam int M_RUN = 0;
  localparam int M_WIC = 1;
  localparam int M_WTLB = 2;

  logic clk;
  logic rst;
  logic ic_req_valid;
  logic [31:0] ic_req_pc;
  logic [TW-1:0] ic_req_thread;
  logic [31:0] ic_rsp_instr;
  logic ic_rsp_miss;
  logic tlb_rsp_miss;
  logic ic_fill_done;
  logic [TW-1:0] ic_fill_thread;
  logic tlb_fill_done;
  logic [TW-1:0] tlb_fill_thread;
  logic redir_valid;
  logic [TW-1:0] redir_thread;
  logic [31:0] redir_pc;
  logic replay_valid;
  logic [TW-1:0] replay_thread;
  logic [31:0] replay_pc;
  logic f_valid;
  logic [TW-1:0] f_thread;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic f_icache_miss;
  logic f_itlb_miss;

  fetch_unit #(.NTHREADS(NT), .BOOT_PC(BOOT)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_pc(ic_req_pc), .ic_req_thread(ic_req_thread),
    .ic_rsp_instr(ic_rsp_instr), .ic_rsp_miss(ic_rsp_miss), .tlb_rsp_miss(tlb_rsp_miss),
    .ic_fill_done(ic_fill_done), .ic_fill_thread(ic_fill_thread),
    .tlb_fill_done(tlb_fill_done), .tlb_fill_thread(tlb_fill_thread),
    .redir_valid(redir_valid), .redir_thread(redir_thread), .redir_pc(redir_pc),
    .replay_valid(replay_valid), .replay_thread(replay_thread), .replay_pc(replay_pc),
    .f_valid(f_valid), .f_thread(f_thread), .f_pc(f_pc), .f_instr(f_instr),
    .f_icache_miss(f_icache_miss), .f_itlb_miss(f_itlb_miss)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [TW+31:0] exp_req_q[$];
  logic [TW+65:0] exp_f_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: per-thread pc/state, last grant, in-flight slot
  logic [31:0] m_pc[NT];
  int m_st[NT];
  int m_last;
  bit m_sv;
  int m_sthr;
  logic [31:0] m_spc;

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_pc[t] = BOOT;
      m_st[t] = M_RUN;
    end
    m_last = NT - 1;
    m_sv = 1'b0;
    m_sthr = 0;
    m_spc = 32'h0;
  endtask

  // Evaluate one cycle with the inputs currently driven.
  task automatic model_step();
    bit touched[NT];
    bit miss;
    int sel;
    if (rst) begin
      model_reset();
      return;
    end
    miss = m_sv && (ic_rsp_miss || (ITLB_EN && tlb_rsp_miss));
    if (m_sv)
      exp_f_q.push_back({TW'(m_sthr), m_spc, ic_rsp_instr, ic_rsp_miss, ITLB_EN & tlb_rsp_miss});
    for (int t = 0; t < NT; t++) begin
      touched[t] = 1'b0;
      if (redir_valid && int'(redir_thread) == t) begin
        m_pc[t] = redir_pc;
        m_st[t] = M_RUN;
        touched[t] = 1'b1;
      end else if (replay_valid && int'(replay_thread) == t) begin
        m_pc[t] = replay_pc;
        touched[t] = 1'b1;
      end else if (miss && m_sthr == t) begin
        m_pc[t] = m_spc;
        m_st[t] = (ITLB_EN && tlb_rsp_miss) ? M_WTLB : M_WIC;
        touched[t] = 1'b1;
      end else if (ic_fill_done && int'(ic_fill_thread) == t && m_st[t] == M_WIC) begin
        m_st[t] = M_RUN;
        touched[t] = 1'b1;
      end else if (ITLB_EN && tlb_fill_done && int'(tlb_fill_thread) == t && m_st[t] == M_WTLB) begin
        m_st[t] = M_RUN;
        touched[t] = 1'b1;
      end
    end
    sel = -1;
    for (int k = 1; k <= NT; k++) begin
      int c;
      c = (m_last + k) % NT;
      if (sel < 0 && m_st[c] == M_RUN && !touched[c]) sel = c;
    end
    if (sel >= 0) begin
      exp_req_q.push_back({TW'(sel), m_pc[sel]});
      m_sv = 1'b1;
      m_sthr = sel;
      m_spc = m_pc[sel];
      m_pc[sel] = m_pc[sel] + 32'd4;
      m_last = sel;
    end else begin
      m_sv = 1'b0;
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    ic_rsp_instr = 32'h0;
    ic_rsp_miss = 1'b0;
    tlb_rsp_miss = 1'b0;
    ic_fill_done = 1'b0;
    ic_fill_thread = '0;
    tlb_fill_done = 1'b0;
    tlb_fill_thread = '0;
    redir_valid = 1'b0;
    redir_thread = '0;
    redir_pc = 32'h0;
    replay_valid = 1'b0;
    replay_thread = '0;
    replay_pc = 32'h0;
  endtask

  task automatic drive_random(input bit quiet);
    drive_idle();
    ic_rsp_instr = $urandom;
    if (quiet) return;
    ic_rsp_miss = ($urandom_range(0, 99) < 15);
    tlb_rsp_miss = ($urandom_range(0, 99) < 10);
    ic_fill_done = ($urandom_range(0, 99) < 40);
    ic_fill_thread = TW'($urandom_range(0, NT - 1));
    tlb_fill_done = ($urandom_range(0, 99) < 30);
    tlb_fill_thread = TW'($urandom_range(0, NT - 1));
    redir_valid = ($urandom_range(0, 99) < 6);
    redir_thread = TW'($urandom_range(0, NT - 1));
    redir_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
    replay_valid = ($urandom_range(0, 99) < 8);
    replay_thread = TW'($urandom_range(0, NT - 1));
    replay_pc = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 99) < 4) begin
      redir_valid = 1'b1;
      replay_valid = 1'b1;
      replay_thread = redir_thread;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      rst = (cyc < 3) || (cyc >= 1500 && cyc < 1502);
      if (rst) drive_idle();
      else drive_random((cyc < 20) || (cyc >= 1502 && cyc < 1510));
      model_step();
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_idle();
    model_step();
    @(negedge clk);
    #1;
    chk("final_req_queue_empty", exp_req_q.size(), 0);
    chk("final_f_queue_empty", exp_f_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ic_req_valid", ic_req_valid, 1'b0);
      chk("rst_f_valid", f_valid, 1'b0);
      chk("rst_req_queue", exp_req_q.size(), 0);
      chk("rst_f_queue", exp_f_q.size(), 0);
      exp_req_q.delete();
      exp_f_q.delete();
    end else begin
      if (ic_req_valid) begin
        if (exp_req_q.size() == 0) chk("req_unexpected", ic_req_valid, 1'b0);
        else chk("req_thread_pc", {ic_req_thread, ic_req_pc}, exp_req_q.pop_front());
      end
      chk("req_missing", exp_req_q.size(), 0);
      exp_req_q.delete();
      if (f_valid) begin
        if (exp_f_q.size() == 0) chk("f_unexpected", f_valid, 1'b0);
        else chk("f_slot", {f_thread, f_pc, f_instr, f_icache_miss, f_itlb_miss}, exp_f_q.pop_front());
      end else begin
        chk("f_miss_flags_idle", {f_icache_miss, f_itlb_miss}, 2'b00);
      end
      chk("f_missing", exp_f_q.size(), 0);
      exp_f_q.delete();
    end
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multithreaded instruction-fetch stage directly upstream of the hazard unit. Holds one PC per hardware thread, picks a ready thread round-robin each cycle, and issues its PC to the I-cache/I-TLB. It then forwards the returned instruction with thread id and miss flags to the hazard unit. Threads that miss park in a wait state until the matching refill completes; redirects from branch resolution and replays from the hazard unit rewrite per-thread PCs.

## Interface
- NTHREADS, 4: number of hardware threads (power of 2, 2..8); TW = $clog2(NTHREADS)
- BOOT_PC, 32'h0000_1000: reset PC of every thread
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ic_req_valid  out  1  lookup request this cycle
- ic_req_pc  out  32  PC looked up
- ic_req_thread  out  TW  requesting thread
- ic_rsp_instr  in  32  instruction, returned one cycle after request
- ic_rsp_miss  in  1  I-cache miss for previous cycle's request
- tlb_rsp_miss  in  1  I-TLB miss for previous cycle's request
- ic_fill_done / ic_fill_thread  in  1 / TW  I-cache refill complete for thread
- tlb_fill_done / tlb_fill_thread  in  1 / TW  I-TLB refill complete for thread
- redir_valid / redir_thread / redir_pc  in  1 / TW / 32  branch redirect
- replay_valid / replay_thread / replay_pc  in  1 / TW / 32  hazard-unit replay request
- f_valid  out  1  fetch slot valid (not squashed)
- f_thread  out  TW  thread of slot
- f_pc  out  32  PC of slot
- f_instr  out  32  = ic_rsp_instr
- f_icache_miss  out  1  = ic_rsp_miss when f_valid, else 0
- f_itlb_miss  out  1  = tlb_rsp_miss when f_valid, else 0

## Operation
- Per-thread state: pc[t] (32 bit), st[t] in {RUN, WAIT_IC, WAIT_TLB}.
- Select (F1): eligible = st[t]==RUN and no update for t this cycle. Round-robin starting at last_sel+1 mod NTHREADS. If none eligible: ic_req_valid=0, last_sel unchanged. On select: ic_req_pc=pc[t], pc[t] <= pc[t]+4 (wraps modulo 2^32).
- Response (F2): register s_valid/s_thread/s_pc at F1; f_* driven from those registers plus same-cycle cache response.
- Miss in F2 (f_valid and either miss flag) for thread t: pc[t] <= f_pc; st[t] <= WAIT_TLB if tlb_rsp_miss, else WAIT_IC (TLB takes precedence); any request of t issued this cycle is squashed (its F2 slot has f_valid=0).
- Fill: ic_fill_done with st[ic_fill_thread]==WAIT_IC -> RUN; tlb_fill_done with st==WAIT_TLB -> RUN. Fills for a thread in any other state are ignored.
- Redirect: pc[redir_thread] <= redir_pc, st <= RUN (cancels any wait), squash in-flight request of that thread.
- Replay: pc[replay_thread] <= replay_pc, st unchanged, squash in-flight request of that thread.
- Same-thread priority in one cycle: rst > redirect > replay > F2 miss > fill > +4 advance. Events on different threads all apply in the same cycle.
- Thread with an update this cycle is ineligible for select this cycle.

## Timing
- Reset values: pc[t]=BOOT_PC, st[t]=RUN, last_sel=NTHREADS-1, s_valid=0. So ic_req_valid=0 and f_valid=0 during rst; first request after rst deassert is thread 0.
- Request-to-f_* latency: 1 cycle. Throughput: 1 instr/cycle while any thread is RUN.
- Miss in cycle N: thread eligible again earliest cycle after the fill_done cycle.
- Squash applies to the slot appearing in f_* the next cycle only.
- rst mid-miss: waits dropped, all threads restart at BOOT_PC.

## Configuration
- FETCH_ITLB_EN defined: WAIT_TLB state, tlb_rsp_miss and tlb_fill_* handled as above.
- Undefined: tlb_rsp_miss and tlb_fill_* ignored, f_itlb_miss tied 0, no WAIT_TLB state; a miss goes only to WAIT_IC.

## Test plan
- Reset, NTHREADS=4, no misses: requests cycle threads 0,1,2,3,0… with PCs 0x1000,0x1000,0x1000,0x1000,0x1004; f_* follows one cycle later.
- ic_rsp_miss on thread 1 PC 0x1004: thread 1 skipped, pc[1]=0x1004; after ic_fill_done thread 1, next thread-1 request is 0x1004.
- NTHREADS=2, single RUN thread misses while its next request is in flight: following slot has f_valid=0; no request until fill.
- redir thread 2 to 0x2000 while in WAIT_IC: st=RUN, next thread-2 request 0x2000; later ic_fill_done for thread 2 ignored.
- Same-cycle redirect(0x3000) and replay(0x1008) on thread 0: pc[0]=0x3000.
- FETCH_ITLB_EN: both miss flags set for thread 3: WAIT_TLB; ic_fill_done ignored; tlb_fill_done resumes at same PC.
